// File: rtl/dispatcher_uart_tx.sv
// dispatcher_uart_tx: pairs dispatcher metric/offset bytes, queues them and sends framed UART packets
// Optional 8E1 parity framing: define DISPATCHER_TX_PARITY_EN
module dispatcher_uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 104,
   parameter int unsigned FIFO_AW      = 2,
   parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] value_in,
   input  logic       rdy_in,
   output logic       tx,
   output logic       busy,
   output logic       overflow
);
   localparam int          PW       = FIFO_AW + 1;
   localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);

   typedef enum logic {CAP_IDLE, CAP_OFS} cap_t;
`ifdef DISPATCHER_TX_PARITY_EN
   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_t;
`else
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_t;
`endif

   cap_t        cap_q, cap_d;
   logic [7:0]  met_q, met_d;
   logic [15:0] mem_q [1 << FIFO_AW];
   logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic        ovf_q, ovf_d;
   tx_t         st_q, st_d;
   logic [15:0] baud_q, baud_d;
   logic [2:0]  bit_q, bit_d;
   logic [1:0]  byte_q, byte_d;
   logic [31:0] sh_q, sh_d;
`ifdef DISPATCHER_TX_PARITY_EN
   logic        par_q, par_d;
`endif
   logic        full, empty, push, push_ok, pop, tick;
   logic [15:0] rd_data;

   assign full     = (wr_q ^ rd_q) == {1'b1, {FIFO_AW{1'b0}}};
   assign empty    = wr_q == rd_q;
   assign push     = cap_q == CAP_OFS;
   assign push_ok  = push && !full;
   assign pop      = st_q == TX_IDLE && !empty;
   assign rd_data  = mem_q[rd_q[FIFO_AW-1:0]];
   assign tick     = baud_q == BAUD_MAX;
   assign busy     = !empty || st_q != TX_IDLE;
   assign overflow = ovf_q;

   // capture: metric on the strobe cycle, offset unconditionally on the cycle after
   always_comb begin
      cap_d = (cap_q == CAP_IDLE && rdy_in) ? CAP_OFS : CAP_IDLE;
      met_d = (cap_q == CAP_IDLE && rdy_in) ? value_in : met_q;
   end

   // fifo pointers: push judged on pre-pop occupancy, a dropped pair latches overflow
   always_comb begin
      wr_d  = wr_q + PW'(push_ok);
      rd_d  = rd_q + PW'(pop);
      ovf_d = ovf_q | (push & full);
   end

   // fifo storage, offset written straight from the bus in the capture's second cycle
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_q[FIFO_AW-1:0]] <= {met_q, value_in};
   end

   // tx sequencer: start, data LSB first, optional parity, stop; four bytes per packet
   always_comb begin
      st_d   = st_q;
      baud_d = tick ? '0 : baud_q + 16'd1;
      bit_d  = bit_q;
      byte_d = byte_q;
      sh_d   = sh_q;
`ifdef DISPATCHER_TX_PARITY_EN
      par_d  = par_q;
`endif
      tx     = 1'b1;
      case (st_q)
         TX_IDLE: begin
            baud_d = '0;
            if (!empty) begin
               st_d   = TX_START;
               byte_d = 2'd0;
               sh_d   = {SYNC_BYTE ^ rd_data[15:8] ^ rd_data[7:0], rd_data[7:0], rd_data[15:8], SYNC_BYTE};
            end
         end
         TX_START: begin
            tx = 1'b0;
            if (tick) begin
               st_d  = TX_DATA;
               bit_d = 3'd0;
`ifdef DISPATCHER_TX_PARITY_EN
               par_d = 1'b0;
`endif
            end
         end
         TX_DATA: begin
            tx = sh_q[0];
            if (tick) begin
               sh_d  = {1'b0, sh_q[31:1]};
               bit_d = bit_q + 3'd1;
`ifdef DISPATCHER_TX_PARITY_EN
               par_d = par_q ^ sh_q[0];
               if (bit_q == 3'd7) st_d = TX_PAR;
`else
               if (bit_q == 3'd7) st_d = TX_STOP;
`endif
            end
         end
`ifdef DISPATCHER_TX_PARITY_EN
         TX_PAR: begin
            tx = par_q;
            if (tick) st_d = TX_STOP;
         end
`endif
         TX_STOP: begin
            if (tick) begin
               st_d   = (byte_q == 2'd3) ? TX_IDLE : TX_START;
               byte_d = byte_q + 2'd1;
            end
         end
         default: st_d = TX_IDLE;
      endcase
   end

   // state registers, all cleared asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cap_q  <= CAP_IDLE;
         met_q  <= '0;
         wr_q   <= '0;
         rd_q   <= '0;
         ovf_q  <= 1'b0;
         st_q   <= TX_IDLE;
         baud_q <= '0;
         bit_q  <= '0;
         byte_q <= '0;
         sh_q   <= '0;
`ifdef DISPATCHER_TX_PARITY_EN
         par_q  <= 1'b0;
`endif
      end else begin
         cap_q  <= cap_d;
         met_q  <= met_d;
         wr_q   <= wr_d;
         rd_q   <= rd_d;
         ovf_q  <= ovf_d;
         st_q   <= st_d;
         baud_q <= baud_d;
         bit_q  <= bit_d;
         byte_q <= byte_d;
         sh_q   <= sh_d;
`ifdef DISPATCHER_TX_PARITY_EN
         par_q  <= par_d;
`endif
      end
   end
endmodule

// File: tb/tb_dispatcher_uart_tx.sv
// tb_dispatcher_uart_tx: randomized bench with a packet-level reference model
module tb_dispatcher_uart_tx;
   localparam int CPB   = 4;
   localparam int DEPTH = 4;
`ifdef DISPATCHER_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int FB   = NB * CPB;
   localparam int PKT  = 4 * FB;
   localparam int MAXC = 32768;

   typedef struct {
      int         n;
      logic [7:0] m;
      logic [7:0] o;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rdy_in = 1'b0;
   logic [7:0] value_in = '0;
   logic       tx, busy, overflow;
   int         cyc_n = 0;
   int         n_chk = 0;
   int         n_err = 0;
   logic       tx_log [MAXC];
   logic       busy_log [MAXC];
   logic       ovf_log [MAXC];
   logic       texp [MAXC];
   ev_t        ev [$];

   dispatcher_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_AW(2), .SYNC_BYTE(8'hA5)) dut (
      .clk(clk), .rst(rst), .value_in(value_in), .rdy_in(rdy_in),
      .tx(tx), .busy(busy), .overflow(overflow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_n <= cyc_n + 1;
   always @(negedge clk) begin
      if (cyc_n < MAXC) begin
         tx_log[cyc_n]   = tx;
         busy_log[cyc_n] = busy;
         ovf_log[cyc_n]  = overflow;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk); #1;
      value_in = 8'($urandom);
   endtask

   task automatic idle(input int k);
      repeat (k) step();
   endtask

   task automatic drive_pair(input logic [7:0] m, input logic [7:0] o, input bit dbl, output int n);
      ev_t e;
      @(posedge clk); #1;
      rdy_in = 1'b1; value_in = m; n = cyc_n;
      e.n = n; e.m = m; e.o = o;
      ev.push_back(e);
      @(posedge clk); #1;
      rdy_in = dbl; value_in = o;
      @(posedge clk); #1;
      rdy_in = 1'b0; value_in = 8'($urandom);
   endtask

   task automatic wait_idle();
      int i = 0;
      step();
      while (busy && i < 4000) begin step(); i++; end
      if (busy) check("idle_timeout", 32'(busy), 0);
      idle(3);
   endtask

   function automatic int first_low(input int s, input int e);
      for (int i = s; i < e; i++) if (tx_log[i] === 1'b0) return i;
      return s;
   endfunction

   function automatic int count_frames(input int s, input int e);
      int i = s, n = 0;
      while (i < e) begin
         if (tx_log[i] === 1'b0) begin n++; i += FB; end
         else i++;
      end
      return n;
   endfunction

   function automatic logic [7:0] byte_at(input int st, input int k);
      logic [7:0] b;
      for (int j = 0; j < 8; j++) b[j] = tx_log[st + k * FB + (j + 1) * CPB + CPB / 2];
      return b;
   endfunction

   // paints the expected line waveform of one packet starting at cycle st
   task automatic paint(input int st, input logic [15:0] p);
      logic [7:0]    b [4];
      logic [NB-1:0] fr;
      int            idx;
      b[0] = 8'hA5; b[1] = p[15:8]; b[2] = p[7:0]; b[3] = b[0] ^ b[1] ^ b[2];
      for (int k = 0; k < 4; k++) begin
`ifdef DISPATCHER_TX_PARITY_EN
         fr = {1'b1, ^b[k], b[k], 1'b0};
`else
         fr = {1'b1, b[k], 1'b0};
`endif
         for (int j = 0; j < NB; j++)
            for (int t = 0; t < CPB; t++) begin
               idx = st + k * FB + j * CPB + t;
               if (idx < MAXC) texp[idx] = fr[j];
            end
      end
   endtask

   // reference model: pair queue plus link-free time, compared with the logged traces
   task automatic check_seg(input int s, input int e, input bit ovf0, input string tag);
      logic [15:0] q [$];
      logic [15:0] p;
      ev_t         x;
      int          free_at, sz0, tb, bb, ob, ft, fb, fo;
      bit          ovf, eb, has, pp;
      free_at = s; ovf = ovf0; tb = 0; bb = 0; ob = 0; ft = -1; fb = -1; fo = -1;
      for (int c = s; c < e + PKT + 2 && c < MAXC; c++) texp[c] = 1'b1;
      for (int c = s; c < e; c++) begin
         eb = (q.size() > 0) || (c < free_at);
         if (tx_log[c] !== texp[c]) begin tb++; if (ft < 0) ft = c; end
         if (busy_log[c] !== eb) begin bb++; if (fb < 0) fb = c; end
         if (ovf_log[c] !== ovf) begin ob++; if (fo < 0) fo = c; end
         has = ev.size() > 0 && ev[0].n + 1 == c;
         sz0 = q.size();
         pp  = c >= free_at && sz0 > 0;
         if (pp) begin
            p = q.pop_front();
            paint(c + 1, p);
            free_at = c + 1 + PKT;
         end
         if (has) begin
            x = ev.pop_front();
            if (sz0 < DEPTH) q.push_back({x.m, x.o});
            else ovf = 1'b1;
         end
      end
      check($sformatf("%s_tx_trace@%0d", tag, ft), tb, 0);
      check($sformatf("%s_busy_trace@%0d", tag, fb), bb, 0);
      check($sformatf("%s_ovf_trace@%0d", tag, fo), ob, 0);
      ev.delete();
   endtask

   initial begin
      #(MAXC * 10);
      $display("FAIL watchdog: cycle %0d, limit %0d", cyc_n, MAXC);
      $fatal(1);
   end

   initial begin
      int n, n1, s, st, tgt, np;
      @(posedge clk); #1;
      check("rst_tx", 32'(tx), 1);
      check("rst_busy", 32'(busy), 0);
      check("rst_ovf", 32'(overflow), 0);
      rst = 1'b0;

      // single pair: latency, byte content and busy length
      s = cyc_n;
      drive_pair(8'h3C, 8'h05, 1'b0, n);
      wait_idle();
      st = first_low(n, cyc_n);
      check("B_latency", st - n, 3);
      check("B_byte0", byte_at(st, 0), 8'hA5);
      check("B_byte1", byte_at(st, 1), 8'h3C);
      check("B_byte2", byte_at(st, 2), 8'h05);
      check("B_chk", byte_at(st, 3), 8'h9C);
      check("B_busy_last", 32'(busy_log[n + 2 + PKT]), 1);
      check("B_busy_end", 32'(busy_log[n + 3 + PKT]), 0);
      check_seg(s, cyc_n, 1'b0, "B");

`ifdef DISPATCHER_TX_PARITY_EN
      s = cyc_n;
      drive_pair(8'h07, 8'($urandom), 1'b0, n);
      wait_idle();
      check("P_parity_bit", 32'(tx_log[n + 3 + FB + 9 * CPB + CPB / 2]), 1);
      check("P_busy_end", 32'(busy_log[n + 3 + PKT]), 0);
      check_seg(s, cyc_n, 1'b0, "P");
`endif

      // strobe held over the offset cycle
      s = cyc_n;
      drive_pair(8'h11, 8'h22, 1'b1, n);
      wait_idle();
      st = first_low(n, cyc_n);
      check("C_ofs", byte_at(st, 2), 8'h22);
      check("C_chk", byte_at(st, 3), 8'h96);
      check("C_frames", count_frames(s, cyc_n), 4);
      check_seg(s, cyc_n, 1'b0, "C");

      // three pairs queued during one packet
      s = cyc_n;
      drive_pair(8'($urandom), 8'($urandom), 1'b0, n1);
      idle($urandom_range(5, 20));
      for (int i = 0; i < 3; i++) begin
         drive_pair(8'($urandom), 8'($urandom), 1'b0, n);
         idle($urandom_range(0, 10));
      end
      wait_idle();
      check("D_gap_idle", 32'(tx_log[n1 + 3 + PKT]), 1);
      check("D_next_start", 32'(tx_log[n1 + 4 + PKT]), 0);
      check("D_frames", count_frames(s, cyc_n), 16);
      check("D_ovf", 32'(overflow), 0);
      check_seg(s, cyc_n, 1'b0, "D");

      // six pairs: one in flight, four queued, one dropped
      s = cyc_n;
      drive_pair(8'($urandom), 8'($urandom), 1'b0, n);
      idle(2);
      for (int i = 0; i < 5; i++) drive_pair(8'($urandom), 8'($urandom), 1'b0, n);
      wait_idle();
      check("E_ovf_sticky", 32'(overflow), 1);
      check("E_frames", count_frames(s, cyc_n), 20);
      check_seg(s, cyc_n, 1'b0, "E");

      // asynchronous reset in a data bit of the second byte
      s = cyc_n;
      drive_pair(8'($urandom), 8'($urandom), 1'b0, n);
      tgt = n + 3 + FB + CPB * (1 + $urandom_range(0, 7)) + 1;
      while (cyc_n < tgt) begin @(posedge clk); #1; end
      @(negedge clk); #2;
      rst = 1'b1;
      #1;
      check("F_rst_tx", 32'(tx), 1);
      check("F_rst_busy", 32'(busy), 0);
      check("F_rst_ovf", 32'(overflow), 0);
      check_seg(s, cyc_n + 1, 1'b1, "F_pre");
      idle(2);
      rst = 1'b0;
      s = cyc_n;
      drive_pair(8'($urandom), 8'($urandom), 1'b0, n);
      wait_idle();
      check("F_frames", count_frames(s, cyc_n), 4);
      check_seg(s, cyc_n, 1'b0, "F_post");

      // random rounds
      for (int r = 0; r < 6; r++) begin
         step();
         rst = 1'b1;
         idle(2);
         rst = 1'b0;
         s = cyc_n;
         np = $urandom_range(1, 7);
         for (int i = 0; i < np; i++) begin
            idle($urandom_range(0, 60));
            drive_pair(8'($urandom), 8'($urandom), $urandom_range(0, 3) == 0, n);
         end
         wait_idle();
         check_seg(s, cyc_n, 1'b0, $sformatf("R%0d", r));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
